// File: rtl/fmul_pkg.sv
// Shared binary32 field layout, bias and canonical encodings for the fmul datapath.
package fmul_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = FRAC_W + 1;
  localparam int unsigned PROD_W  = 2 * MANT_W;
  localparam int unsigned EEXT_W  = 11;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [WORD_W-1:0] QNAN     = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF  = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] NEG_INF  = 32'hFF80_0000;
  localparam logic [WORD_W-1:0] POS_ZERO = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NEG_ZERO = 32'h8000_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } f32_t;

endpackage

// File: rtl/fmul_if.sv
// Operand/result bundle for fmul: two binary32 operands in, product and overflow out.
interface fmul_if;
  import fmul_pkg::*;

  logic [WORD_W-1:0] x1;
  logic [WORD_W-1:0] x2;
  logic [WORD_W-1:0] y;
  logic              ovf;

  modport master (output x1, output x2, input y, input ovf);
  modport slave  (input x1, input x2, output y, output ovf);

endinterface

// File: rtl/fmul_round.sv
// Normalises the 48-bit mantissa product and rounds to nearest-even on 23 fraction bits.
module fmul_round
  import fmul_pkg::*;
(
  input  logic [PROD_W-1:0]        prod,
  input  logic signed [EEXT_W-1:0] exp_in,
  output logic [FRAC_W-1:0]        frac,
  output logic signed [EEXT_W-1:0] exp_out
);

  logic [FRAC_W-1:0]        mant;
  logic                     guard;
  logic                     sticky;
  logic                     up;
  logic [MANT_W-1:0]        sum;
  logic signed [EEXT_W-1:0] exp_n;

  always_comb begin
    mant   = prod[PROD_W-3 -: FRAC_W];
    guard  = prod[PROD_W-3-FRAC_W];
    sticky = |prod[PROD_W-4-FRAC_W:0];
    exp_n  = exp_in;
    // product in [2,4): take the window one bit higher and bump the exponent
    if (prod[PROD_W-1]) begin
      mant   = prod[PROD_W-2 -: FRAC_W];
      guard  = prod[PROD_W-2-FRAC_W];
      sticky = |prod[PROD_W-3-FRAC_W:0];
      exp_n  = exp_in + 11'sd1;
    end
    up      = guard & (sticky | mant[0]);
    sum     = {1'b0, mant} + MANT_W'(up);
    frac    = sum[FRAC_W-1:0];
    // all-ones fraction rounded up wraps to 1.0 of the next binade
    exp_out = sum[FRAC_W] ? exp_n + 11'sd1 : exp_n;
  end

endmodule

// File: rtl/fmul.sv
// Single-cycle binary32 multiplier: combinational datapath feeding one output register.
module fmul
  import fmul_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  fmul_if.slave bus
);

  f32_t                     a;
  f32_t                     b;
  logic                     s;
  logic                     a_zero, b_zero;
  logic                     a_inf, b_inf;
  logic                     a_nan, b_nan;
  logic [PROD_W-1:0]        prod;
  logic signed [EEXT_W-1:0] exp_sum;
  logic [FRAC_W-1:0]        frac_r;
  logic signed [EEXT_W-1:0] exp_r;
  logic [WORD_W-1:0]        y_c;
  logic                     ovf_c;
  logic [WORD_W-1:0]        y_q;
  logic                     ovf_q;

  assign a = bus.x1;
  assign b = bus.x2;
  assign s = a.sign ^ b.sign;

  // exp==0 covers denormals, which are flushed to zero
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);
  assign a_inf  = (a.exp == EXP_W'(EXP_MAX)) && (a.frac == '0);
  assign b_inf  = (b.exp == EXP_W'(EXP_MAX)) && (b.frac == '0);
  assign a_nan  = (a.exp == EXP_W'(EXP_MAX)) && (a.frac != '0);
  assign b_nan  = (b.exp == EXP_W'(EXP_MAX)) && (b.frac != '0);

  assign prod    = PROD_W'({1'b1, a.frac}) * PROD_W'({1'b1, b.frac});
  assign exp_sum = EEXT_W'(a.exp) + EEXT_W'(b.exp) - EEXT_W'(BIAS);

  fmul_round u_round (
    .prod    (prod),
    .exp_in  (exp_sum),
    .frac    (frac_r),
    .exp_out (exp_r)
  );

  // special-case select; ovf only from a finite result that saturated
  always_comb begin
    y_c   = {s, exp_r[EXP_W-1:0], frac_r};
    ovf_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y_c = {s, QNAN[WORD_W-2:0]};
    end else if (a_inf || b_inf) begin
      y_c = {s, POS_INF[WORD_W-2:0]};
    end else if (a_zero || b_zero) begin
      y_c = {s, POS_ZERO[WORD_W-2:0]};
    end else if (exp_r >= $signed(EEXT_W'(EXP_MAX))) begin
      y_c   = {s, POS_INF[WORD_W-2:0]};
      ovf_c = 1'b1;
    end else if (exp_r <= 11'sd0) begin
      y_c = {s, POS_ZERO[WORD_W-2:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_c;
      ovf_q <= ovf_c;
    end
  end

  assign bus.y   = y_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_fmul.sv
// Directed-vector bench for fmul with hand-computed products, specials and async reset.
module tb_fmul;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fmul_if bus ();

  fmul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // drive on the falling edge, sample 1 time unit after the next rising edge
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ey, input logic eovf);
    @(negedge clk);
    bus.x1 = a;
    bus.x2 = b;
    @(posedge clk);
    #1;
    check({tag, ".y"}, bus.y, ey);
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(eovf));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.x1 = 32'h0;
    bus.x2 = 32'h0;
    #2;
    check("rst_y", bus.y, 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run("one",       32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
    run("mix",       32'h3FC00000, 32'hC0000000, 32'hC0400000, 1'b0);
    run("rnd_lo",    32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0);
    run("rnd_hi",    32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0);
    run("ovf",       32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);
    run("inf_one",   32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0);
    run("unf",       32'h00800000, 32'h80800000, 32'h80000000, 1'b0);
    run("denorm",    32'h00400000, 32'h7F000000, 32'h00000000, 1'b0);
    run("inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0);
    run("nan",       32'h7FC00001, 32'hBF800000, 32'hFFC00000, 1'b0);
    run("zero_neg",  32'h00000000, 32'hBF800000, 32'h80000000, 1'b0);
    run("inf_neg",   32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0);
    run("neg_ovf",   32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1);
    run("half_half", 32'h3F000000, 32'h3F000000, 32'h3E800000, 1'b0);
    run("rnd_carry", 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 1'b0);

    // back-to-back stream, then reset asserted between clock edges
    run("stream0",   32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    run("stream1",   32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1);
    @(negedge clk);
    bus.x1 = 32'h40000000;
    bus.x2 = 32'h40000000;
    #2;
    rst = 1'b1;
    #1;
    check("async_y", bus.y, 32'h0);
    check("async_ovf", 32'(bus.ovf), 32'h0);
    @(posedge clk);
    #1;
    check("held_y", bus.y, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    bus.x1 = 32'h3F800000;
    bus.x2 = 32'h3FC00000;
    #1;
    check("rel_y", bus.y, 32'h0);
    @(posedge clk);
    #1;
    check("resume_y", bus.y, 32'h3FC00000);
    check("resume_ovf", 32'(bus.ovf), 32'h0);
    run("resume2",   32'h40800000, 32'hC0800000, 32'hC1800000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmul.md
FMUL -- requirements
Module: fmul

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 x1  input  32  operand A, binary32 {sign, exp[7:0], frac[22:0]}.
REQ-005 x2  input  32  operand B, same format.
REQ-006 y  output  32  product x1*x2, binary32, registered.
REQ-007 ovf  output  1  overflow flag, registered, aligned with y.

Function
REQ-008 Latency SHALL be exactly 1 clk: y/ovf after edge N reflect x1/x2 sampled at edge N; one new operation per cycle, no handshake.
REQ-009 Result sign SHALL be x1[31] XOR x2[31] in every case, including zero, infinity and NaN results.
REQ-010 An operand with exp==0 SHALL be treated as signed zero (denormals flushed on input).
REQ-011 Normal path: 24x24-bit product of {1,frac} mantissas (48 bits); biased exponent e = e1+e2-127, plus 1 when product bit 47 is set (normalise right by one).
REQ-012 Rounding SHALL be round-to-nearest-even on the 23-bit fraction using guard bit plus sticky OR of all lower bits; a rounding carry out of the mantissa SHALL increment e and renormalise.
REQ-013 After rounding, if e>=255 (signed 11-bit compare, no wrap), y SHALL be signed infinity {s,8'hFF,23'h0}.
REQ-014 After rounding, if e<=0, y SHALL be signed zero {s,31'h0} (no denormal outputs).
REQ-015 Zero operand (exp==0) times a finite operand SHALL give signed zero.
REQ-016 If either operand is NaN, or infinity times zero, y SHALL be {s,8'hFF,23'h400000} (quiet NaN).
REQ-017 Infinity times a nonzero finite or infinite operand SHALL give signed infinity.
REQ-018 ovf SHALL be 1 iff both operand exponents are <255 and y's exponent is 255; otherwise 0, including for inf/NaN inputs and underflow.

Reset
REQ-019 While rst=1, y SHALL be 32'h0 and ovf 0, immediately and independent of clk.
REQ-020 Any in-flight result SHALL be discarded on reset; the first valid output after deassertion is the operation sampled at the first rising edge with rst=0.

Structure
REQ-021 A shared package SHALL hold the binary32 field widths, bias (127), exponent-max (255) and canonical constants (QNaN, +/-inf, +/-zero).
REQ-022 Combinational datapath (unpack, multiply, normalise, round, special-case select) SHALL sit before a single output register stage.
REQ-023 One sub-module is natural: fmul_round (48-bit product plus exponent in, rounded 23-bit fraction plus adjusted exponent out); the multiplier itself is inferred.

Verification
REQ-024 0x3F800000 * 0x3F800000 -> y=0x3F800000, ovf=0, one cycle later; 0x3FC00000 * 0xC0000000 -> y=0xC0400000.
REQ-025 Rounding: 0x3F800001 * 0x3F800001 -> 0x3F800002; 0x3FFFFFFF * 0x3FFFFFFF -> 0x407FFFFE.
REQ-026 Overflow: 0x7F000000 * 0x7F000000 -> y=0x7F800000, ovf=1; 0x7F800000 * 0x3F800000 -> y=0x7F800000, ovf=0.
REQ-027 Underflow/flush: 0x00800000 * 0x80800000 -> y=0x80000000, ovf=0; denormal 0x00400000 * 0x7F000000 -> 0x00000000.
REQ-028 Specials: 0x7F800000 * 0x00000000 -> 0x7FC00000; 0x7FC00001 * 0xBF800000 -> 0xFFC00000, ovf=0.
REQ-029 Reset: stream back-to-back operands, assert rst mid-stream -> y=0, ovf=0 without a clock edge; after release, results resume with 1-cycle latency.
